// File: rtl/float24_pkg.sv
// float24_pkg: shared definitions for the 24-bit float format
// (sign [23], exponent [22:16] with bias 63, fraction [15:0] with hidden 1,
// exponent 0 encodes zero, no denormals) and for the accumulator datapath.
// No ports; imported by float_accumulator, float24_norm_round and the bus
// interface.
package float24_pkg;

  localparam int EXP_W    = 7;
  localparam int MAN_W    = 16;
  localparam int BIAS     = 63;
  localparam int GRD_W    = 2;

  localparam int FLOAT_W  = 1 + EXP_W + MAN_W;
  localparam int SIGN_BIT = FLOAT_W - 1;
  localparam int EXP_MSB  = SIGN_BIT - 1;
  localparam int EXP_LSB  = MAN_W;
  localparam int FRAC_MSB = MAN_W - 1;

  // Working mantissa: hidden bit, stored fraction, guard bits.
  localparam int WM_W     = 1 + MAN_W + GRD_W;
  // Working exponent: two's complement with room for exp+1 above the
  // largest code and for the negative values normalisation can reach.
  localparam int XW       = EXP_W + 2;
  // Beyond this exponent difference the smaller operand vanishes entirely.
  localparam int BIG_SHIFT = MAN_W + GRD_W + 1;

  localparam logic [EXP_W-1:0] EXP_MAX  = '1;
  localparam logic [MAN_W-1:0] FRAC_MAX = '1;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } float24_t;

  localparam float24_t MAX_MAG = {1'b0, EXP_MAX, FRAC_MAX};

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

  // Expand a stored float into the working mantissa; zero stays all zeros.
  function automatic logic [WM_W-1:0] working_man(input float24_t f);
    if (f.exp == '0) begin
      return '0;
    end
    return {1'b1, f.frac, {GRD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/float_accumulator_if.sv
// float_accumulator_if: operand and result bus of the float accumulator.
//   in_valid/in_ready   operand handshake (transfer when both high)
//   in_float            operand, float24 format
//   in_overflow         upstream overflow flag for the operand
//   in_underflow        upstream underflow flag, operand treated as zero
//   in_last             operand closes the batch
//   acc_valid           one-cycle pulse, result fields valid
//   acc_float           batch sum, held until the next pulse
//   acc_overflow        sticky batch overflow, held with acc_float
//   acc_underflow       sticky batch underflow, held with acc_float
// Modports: master = operand producer / result consumer, slave = accumulator.
interface float_accumulator_if;
  import float24_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [FLOAT_W-1:0] in_float;
  logic               in_overflow;
  logic               in_underflow;
  logic               in_last;
  logic               acc_valid;
  logic [FLOAT_W-1:0] acc_float;
  logic               acc_overflow;
  logic               acc_underflow;

  modport master (
    output in_valid, in_float, in_overflow, in_underflow, in_last,
    input  in_ready, acc_valid, acc_float, acc_overflow, acc_underflow
  );

  modport slave (
    input  in_valid, in_float, in_overflow, in_underflow, in_last,
    output in_ready, acc_valid, acc_float, acc_overflow, acc_underflow
  );

endinterface

// File: rtl/float24_norm_round.sv
// float24_norm_round: combinational finishing stage for a normalised
// working result. Applies optional rounding, then the exponent bounds:
// saturation to the largest magnitude on overflow, flush to +0 on underflow.
//   sign       result sign
//   exp_in     working exponent (two's complement, XW bits)
//   man_in     normalised working mantissa, hidden bit at the top
//   sticky     OR of all bits lost below the guard field
//   result     packed float24 result
//   overflow   exponent exceeded the largest code
//   underflow  exponent fell below 1, result flushed
// Build option: FACC_ROUND_EN selects round-to-nearest-even; otherwise the
// guard and sticky bits are truncated.
module float24_norm_round
  import float24_pkg::*;
(
  input  logic            sign,
  input  logic [XW-1:0]   exp_in,
  input  logic [WM_W-1:0] man_in,
  input  logic            sticky,
  output float24_t        result,
  output logic            overflow,
  output logic            underflow
);

  logic [XW-1:0]    rnd_exp;
  logic [MAN_W-1:0] rnd_frac;

`ifdef FACC_ROUND_EN
  logic round_up;
  logic rnd_carry;

  // Round bit is the top guard bit; ties go to an even LSB. A carry out of
  // the fraction leaves it all zeros, which is exactly 1.0 at exp+1.
  always_comb begin
    round_up = man_in[GRD_W-1] &
               ((|man_in[GRD_W-2:0]) | sticky | man_in[GRD_W]);
    {rnd_carry, rnd_frac} = {1'b0, man_in[WM_W-2:GRD_W]} +
                            {{MAN_W{1'b0}}, round_up};
    rnd_exp = rnd_carry ? exp_in + XW'(1) : exp_in;
  end
`else
  logic unused_rnd;

  assign unused_rnd = ^{man_in[GRD_W-1:0], sticky};
  assign rnd_frac   = man_in[WM_W-2:GRD_W];
  assign rnd_exp    = exp_in;
`endif

  // A clear hidden bit means the sum cancelled exactly: plain +0, no flag.
  always_comb begin
    result    = '0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (man_in[WM_W-1]) begin
      if (!rnd_exp[XW-1] && rnd_exp[XW-2]) begin
        result      = MAX_MAG;
        result.sign = sign;
        overflow    = 1'b1;
      end else if (rnd_exp[XW-1] || rnd_exp == '0) begin
        underflow = 1'b1;
      end else begin
        result = {sign, rnd_exp[EXP_W-1:0], rnd_frac};
      end
    end
  end

endmodule

// File: rtl/float_accumulator.sv
// float_accumulator: multi-cycle sequential adder summing a stream of
// float24 products into one result per batch.
//   clk    clock, rising edge
//   rst    asynchronous active-low reset
//   clear  synchronous clear of accumulator and sticky flags, aborts any
//          operation in flight without a result pulse
//   bus    float_accumulator_if.slave: operand handshake and batch result
// Flow per operand: IDLE -> ALIGN (bit-serial) -> ADD -> NORM (bit-serial)
// -> DONE. Build option: FACC_ROUND_EN enables round-to-nearest-even in DONE.
module float_accumulator
  import float24_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  float_accumulator_if.slave bus
);

  localparam logic [XW-1:0] EXP_ONE = XW'(1);

  state_t          state;
  logic            a_sign, b_sign, r_sign;
  logic [XW-1:0]   a_exp, b_exp, r_exp;
  logic [WM_W-1:0] a_man, b_man;
  logic [WM_W:0]   sum;
  logic            sticky;
  logic            last_q;
  logic            ovf_q, unf_q;

  logic            ready, xfer;
  logic            a_bigger;
  logic [XW-1:0]   exp_diff;
  logic [WM_W:0]   add_mag;
  logic            add_sign;
  float24_t        in_op;
  float24_t        nr_result;
  logic            nr_ovf, nr_unf;

  assign in_op        = bus.in_float;
  assign ready        = rst && !clear && (state == IDLE);
  assign bus.in_ready = ready;
  assign xfer         = bus.in_valid && ready;

  // Sign-magnitude add of the aligned operands; an unequal-sign result
  // takes the sign of the larger magnitude.
  always_comb begin
    a_bigger = a_exp > b_exp;
    exp_diff = a_bigger ? a_exp - b_exp : b_exp - a_exp;
    add_sign = a_sign;
    if (a_sign == b_sign) begin
      add_mag = {1'b0, a_man} + {1'b0, b_man};
    end else if (a_man >= b_man) begin
      add_mag = {1'b0, a_man} - {1'b0, b_man};
    end else begin
      add_mag  = {1'b0, b_man} - {1'b0, a_man};
      add_sign = b_sign;
    end
  end

  float24_norm_round u_norm_round (
    .sign      (r_sign),
    .exp_in    (r_exp),
    .man_in    (sum[WM_W-1:0]),
    .sticky    (sticky),
    .result    (nr_result),
    .overflow  (nr_ovf),
    .underflow (nr_unf)
  );

  // The accumulator (a_*) doubles as the working copy during alignment;
  // DONE always rewrites it, and clear/reset discard it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      a_sign            <= 1'b0;
      a_exp             <= '0;
      a_man             <= '0;
      b_sign            <= 1'b0;
      b_exp             <= '0;
      b_man             <= '0;
      r_sign            <= 1'b0;
      r_exp             <= '0;
      sum               <= '0;
      sticky            <= 1'b0;
      last_q            <= 1'b0;
      ovf_q             <= 1'b0;
      unf_q             <= 1'b0;
      bus.acc_valid     <= 1'b0;
      bus.acc_float     <= '0;
      bus.acc_overflow  <= 1'b0;
      bus.acc_underflow <= 1'b0;
    end else if (clear) begin
      state         <= IDLE;
      a_sign        <= 1'b0;
      a_exp         <= '0;
      a_man         <= '0;
      sticky        <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      bus.acc_valid <= 1'b0;
    end else begin
      bus.acc_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer) begin
            if (bus.in_underflow || in_op.exp == '0) begin
              b_sign <= 1'b0;
              b_exp  <= '0;
              b_man  <= '0;
            end else begin
              b_sign <= in_op.sign;
              b_exp  <= {2'b00, in_op.exp};
              b_man  <= working_man(in_op);
            end
            sticky <= 1'b0;
            last_q <= bus.in_last;
            ovf_q  <= ovf_q | bus.in_overflow;
            unf_q  <= unf_q | bus.in_underflow;
            state  <= ALIGN;
          end
        end

        // One right shift of the smaller operand per cycle; the shift that
        // equalises the exponents also moves on to ADD.
        ALIGN: begin
          if (a_exp == '0 || b_exp == '0 || a_exp == b_exp) begin
            state <= ADD;
          end else if (exp_diff > XW'(BIG_SHIFT)) begin
            if (a_bigger) begin
              b_man <= '0;
              b_exp <= a_exp;
            end else begin
              a_man <= '0;
              a_exp <= b_exp;
            end
            sticky <= 1'b1;
            state  <= ADD;
          end else begin
            if (a_bigger) begin
              b_man  <= b_man >> 1;
              b_exp  <= b_exp + EXP_ONE;
              sticky <= sticky | b_man[0];
            end else begin
              a_man  <= a_man >> 1;
              a_exp  <= a_exp + EXP_ONE;
              sticky <= sticky | a_man[0];
            end
            if (exp_diff == EXP_ONE) begin
              state <= ADD;
            end
          end
        end

        ADD: begin
          if (add_mag == '0) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
            sum    <= '0;
            state  <= DONE;
          end else begin
            r_sign <= add_sign;
            r_exp  <= a_bigger ? a_exp : b_exp;
            sum    <= add_mag;
            state  <= NORM;
          end
        end

        // A carry needs exactly one right shift; otherwise shift left until
        // the hidden bit is set, leaving as soon as the next one will be.
        NORM: begin
          if (sum[WM_W]) begin
            sum    <= sum >> 1;
            sticky <= sticky | sum[0];
            r_exp  <= r_exp + EXP_ONE;
            state  <= DONE;
          end else if (sum[WM_W-1]) begin
            state <= DONE;
          end else begin
            sum   <= sum << 1;
            r_exp <= r_exp - EXP_ONE;
            if (sum[WM_W-2]) begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          if (last_q) begin
            bus.acc_float     <= nr_result;
            bus.acc_overflow  <= ovf_q | nr_ovf;
            bus.acc_underflow <= unf_q | nr_unf;
            bus.acc_valid     <= 1'b1;
            a_sign            <= 1'b0;
            a_exp             <= '0;
            a_man             <= '0;
            ovf_q             <= 1'b0;
            unf_q             <= 1'b0;
          end else begin
            a_sign <= nr_result.sign;
            a_exp  <= {2'b00, nr_result.exp};
            a_man  <= working_man(nr_result);
            ovf_q  <= ovf_q | nr_ovf;
            unf_q  <= unf_q | nr_unf;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_accumulator.sv
// tb_float_accumulator: scoreboard bench for float_accumulator. Expected
// batch results are queued as the closing operand is driven and compared
// when acc_valid pulses.
module tb_float_accumulator;
  import float24_pkg::*;

  localparam logic [23:0] ONE_F = {1'b0, EXP_W'(BIAS), {MAN_W{1'b0}}};

  typedef struct {
    logic [23:0] value;
    logic        ovf;
    logic        unf;
    int          latency;
  } expect_t;

  logic clk;
  logic rst;
  logic clear;

  float_accumulator_if bus();

  float_accumulator dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  expect_t sbQueue[$];
  int checkCount     = 0;
  int passCount      = 0;
  int cycleCount     = 0;
  int xferCycle      = 0;
  int pulseCount     = 0;
  int expectedPulses = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (observed === expected) begin
      passCount = passCount + 1;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Result monitor: pops one expectation per acc_valid pulse.
  always @(negedge clk) begin : monitor
    expect_t e;
    if (rst === 1'b1 && bus.acc_valid === 1'b1) begin
      pulseCount = pulseCount + 1;
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("acc_float", {8'h00, bus.acc_float}, {8'h00, e.value});
        checkOutput("acc_overflow", {31'd0, bus.acc_overflow}, {31'd0, e.ovf});
        checkOutput("acc_underflow", {31'd0, bus.acc_underflow}, {31'd0, e.unf});
        if (e.latency >= 0) begin
          checkOutput("latency", cycleCount - xferCycle, e.latency);
        end
      end
    end
  end

  task automatic expectResult(input logic [23:0] value, input logic ovf,
                              input logic unf, input int latency);
    expect_t e;
    e.value   = value;
    e.ovf     = ovf;
    e.unf     = unf;
    e.latency = latency;
    sbQueue.push_back(e);
    expectedPulses = expectedPulses + 1;
  endtask

  task automatic applyStimulus(input logic [23:0] value, input logic last,
                               input logic ovf = 1'b0, input logic unf = 1'b0);
    int waitCycles = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waitCycles < 200) begin
      @(negedge clk);
      waitCycles = waitCycles + 1;
    end
    if (bus.in_ready !== 1'b1) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.in_valid     = 1'b1;
    bus.in_float     = value;
    bus.in_last      = last;
    bus.in_overflow  = ovf;
    bus.in_underflow = unf;
    @(posedge clk);
    #1;
    xferCycle        = cycleCount;
    bus.in_valid     = 1'b0;
    bus.in_last      = 1'b0;
    bus.in_overflow  = 1'b0;
    bus.in_underflow = 1'b0;
  endtask

  task automatic waitDrain();
    int waitCycles = 0;
    while (sbQueue.size() != 0 && waitCycles < 200) begin
      @(negedge clk);
      waitCycles = waitCycles + 1;
    end
    if (sbQueue.size() != 0) begin
      checkOutput("drain_timeout", sbQueue.size(), 32'd0);
      sbQueue.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst              = 1'b0;
    clear            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_float     = '0;
    bus.in_last      = 1'b0;
    bus.in_overflow  = 1'b0;
    bus.in_underflow = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_acc_valid", {31'd0, bus.acc_valid}, 32'd0);
    checkOutput("reset_acc_float", {8'h00, bus.acc_float}, 32'd0);
    checkOutput("reset_acc_overflow", {31'd0, bus.acc_overflow}, 32'd0);
    checkOutput("reset_acc_underflow", {31'd0, bus.acc_underflow}, 32'd0);
    rst = 1'b1;
    #1 checkOutput("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

    // 1.0 + 1.0 = 2.0
    applyStimulus(ONE_F, 1'b0);
    expectResult(24'h400000, 1'b0, 1'b0, 4);
    applyStimulus(ONE_F, 1'b1);
    waitDrain();

    // 1.5 - 1.0 = 0.5
    applyStimulus(24'h3F8000, 1'b0);
    expectResult(24'h3E0000, 1'b0, 1'b0, -1);
    applyStimulus(24'hBF0000, 1'b1);
    waitDrain();

    // exact cancellation gives +0 without flags
    applyStimulus(ONE_F, 1'b0);
    expectResult(24'h000000, 1'b0, 1'b0, -1);
    applyStimulus(24'hBF0000, 1'b1);
    waitDrain();

    // largest magnitude twice saturates
    applyStimulus(24'h7FFFFF, 1'b0);
    expectResult(24'h7FFFFF, 1'b1, 1'b0, -1);
    applyStimulus(24'h7FFFFF, 1'b1);
    waitDrain();

    // sticky flags start fresh for the next batch
    expectResult(ONE_F, 1'b0, 1'b0, -1);
    applyStimulus(ONE_F, 1'b1);
    waitDrain();

    // 1.0 + 1.5*2^-17: guard bits 11 decide the rounding
    applyStimulus(ONE_F, 1'b0);
`ifdef FACC_ROUND_EN
    expectResult(24'h3F0001, 1'b0, 1'b0, -1);
`else
    expectResult(24'h3F0000, 1'b0, 1'b0, -1);
`endif
    applyStimulus(24'h2E8000, 1'b1);
    waitDrain();

    // exponent difference 31 takes the single-cycle discard path
    applyStimulus(ONE_F, 1'b0);
    expectResult(ONE_F, 1'b0, 1'b0, 4);
    applyStimulus(24'h200000, 1'b1);
    waitDrain();

    // upstream underflow: operand treated as zero, flag carried
    expectResult(24'h000000, 1'b0, 1'b1, -1);
    applyStimulus(ONE_F, 1'b1, 1'b0, 1'b1);
    waitDrain();

    // upstream overflow flag carried with an ordinary sum
    expectResult(ONE_F, 1'b1, 1'b0, -1);
    applyStimulus(ONE_F, 1'b1, 1'b1, 1'b0);
    waitDrain();

    // 1.5*2^-62 - 1.0*2^-62 falls below the smallest exponent
    applyStimulus(24'h018000, 1'b0);
    expectResult(24'h000000, 1'b0, 1'b1, -1);
    applyStimulus(24'h810000, 1'b1);
    waitDrain();

    // 2.0 - 1.0 needs one alignment shift and one left normalisation
    applyStimulus(24'h400000, 1'b0);
    expectResult(ONE_F, 1'b0, 1'b0, -1);
    applyStimulus(24'hBF0000, 1'b1);
    waitDrain();

    // three-operand batch: 1 + 1 + 1 = 3.0
    applyStimulus(ONE_F, 1'b0);
    applyStimulus(ONE_F, 1'b0);
    expectResult(24'h408000, 1'b0, 1'b0, -1);
    applyStimulus(ONE_F, 1'b1);
    waitDrain();

    // clear wins over a same-cycle transfer offer
    @(negedge clk);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_float = ONE_F;
    bus.in_last  = 1'b1;
    #1 checkOutput("ready_during_clear", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    // clear during a long alignment aborts the batch and the accumulator
    applyStimulus(ONE_F, 1'b0);
    applyStimulus(24'h2E8000, 1'b1);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1 checkOutput("ready_after_clear", {31'd0, bus.in_ready}, 32'd1);
    repeat (40) @(negedge clk);
    expectResult(ONE_F, 1'b0, 1'b0, -1);
    applyStimulus(ONE_F, 1'b1);
    waitDrain();

    // asynchronous reset in the middle of a 16-step normalisation
    applyStimulus(24'h3F0001, 1'b0);
    applyStimulus(24'hBF0000, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midreset_acc_valid", {31'd0, bus.acc_valid}, 32'd0);
    checkOutput("midreset_acc_float", {8'h00, bus.acc_float}, 32'd0);
    checkOutput("midreset_acc_overflow", {31'd0, bus.acc_overflow}, 32'd0);
    checkOutput("midreset_acc_underflow", {31'd0, bus.acc_underflow}, 32'd0);
    checkOutput("midreset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("ready_after_midreset", {31'd0, bus.in_ready}, 32'd1);

    checkOutput("pulse_count", pulseCount, expectedPulses);
    checkOutput("queue_empty", sbQueue.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/float_accumulator.md
Name: float_accumulator

Overview:
- Downstream consumer of the 24-bit float multiplier output: sums a stream of products in the same sign/exp/mantissa format and yields one sum per batch (MAC back end).
- Multi-cycle sequential adder. FSM with bit-serial alignment and normalisation. valid/ready on input, one-cycle result pulse on output.

Parameters:
- EXP_W, 7, exponent width; float word bits [22:16].
- MAN_W, 16, stored fraction width; bits [15:0], hidden leading 1.
- BIAS, 63, exponent bias; exp==0 encodes zero, no denormals.
- GRD_W, 2, guard bits below LSB during alignment; a sticky bit is kept in addition.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of accumulator and flags.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept operand; high only in IDLE.
- in_float  in  24  operand: [23] sign, [22:16] exp, [15:0] fraction.
- in_overflow  in  1  upstream overflow flag for this operand.
- in_underflow  in  1  upstream underflow flag; operand treated as zero.
- in_last  in  1  operand closes the batch.
- acc_valid  out  1  one-cycle pulse; result fields valid.
- acc_float  out  24  batch sum, held until next pulse.
- acc_overflow  out  1  sticky batch overflow, held with acc_float.
- acc_underflow  out  1  sticky batch underflow, held with acc_float.

Behaviour:
- Reset (rst=0, async): state IDLE. Accumulator=+0. Sticky flags=0. acc_valid=0, acc_float=0, acc_overflow=0, acc_underflow=0. in_ready=1 once reset deasserts.
- Transfer occurs on in_valid&&in_ready at a clock edge. The operand, in_last and the flags are latched. in_overflow/in_underflow are ORed into the sticky flags.
- FSM:
  - IDLE: wait for transfer → ALIGN.
  - ALIGN: working mantissas are {1,frac,GRD_W zeros} (zero operand = all zeros). Each cycle, shift the smaller-exponent mantissa right 1 bit and increment its exponent. Bits shifted past the guard field OR into sticky. If exp difference > MAN_W+GRD_W+1, replace the smaller mantissa with 0 and set sticky in one cycle. Go to ADD when exponents are equal or either operand is zero.
  - ADD: sign-magnitude. Equal signs: add. Unequal signs: subtract smaller magnitude from larger; result takes sign of larger. Exact zero → +0 (exp 0) → DONE. Otherwise → NORM.
  - NORM: on carry-out, shift right 1 and exp+1 (one cycle). Otherwise shift left 1 per cycle, exp-1, until hidden bit is 1 → DONE.
  - DONE: apply bounds and optional rounding, write accumulator. If latched in_last: drive acc_float/flags, pulse acc_valid, reset accumulator to +0 and sticky flags to 0. → IDLE.
- Default rounding: truncate guard and sticky bits.
- Overflow: exp > 2^EXP_W-1 → saturate to sign,7'h7F,16'hFFFF; set sticky overflow.
- Underflow: exp < 1 after normalisation → flush to +0; set sticky underflow.
- Latency, transfer to acc_valid: 3 + align shifts + norm shifts. Worst case ≈ 2*(MAN_W+GRD_W)+5 cycles.
- clear=1: next edge forces IDLE, accumulator +0, sticky 0. An in-flight operation is aborted, no acc_valid. clear beats a same-cycle transfer (in_ready=0 while clear=1). acc_* outputs keep their last values.
- Mid-operation reset: all state returns to reset values immediately.

Optional Feature:
- FACC_ROUND_EN defined: DONE rounds to nearest-even using guard and sticky bits. Mantissa carry from rounding re-normalises (exp+1) in the same cycle, with overflow checked after rounding.
- Undefined: truncation only; guard/sticky logic is still present but ignored.

Decomposition:
- Package float24_pkg: EXP_W, MAN_W, BIAS, field bit positions, FSM state enum, max-magnitude constant, and a float24 struct (sign, exp, frac).
- One sub-module, float24_norm_round: combinational bounds check, saturate/flush and optional rounding, used in DONE.

Test Plan:
- Feed 0x3F0000 then 0x3F0000 (last) → acc_float=0x400000 (2.0), flags 0, single acc_valid pulse.
- Feed 0x3F8000 (1.5) then 0xBF0000 (-1.0, last) → 0x3E0000 (0.5). Feed 0x3F0000 then 0xBF0000 → 0x000000.
- Feed 0x7FFFFF twice → 0x7FFFFF, acc_overflow=1. Next batch 0x3F0000 (last) → flags back to 0.
- Feed 0x3F0000 then 0x2E8000 (1.5·2^-17, last). Without FACC_ROUND_EN → 0x3F0000. With it → 0x3F0001.
- Feed 0x3F0000 then 0x200000 (exp diff 31, last) → 0x3F0000 via single-cycle big-shift path. Check latency = 4 cycles from transfer to acc_valid.
- Assert clear during ALIGN → no acc_valid, in_ready=1 next cycle. Then feed 0x3F0000 (last) → 0x3F0000. Pulse rst low mid-NORM → all outputs 0 asynchronously.
